// File: rtl/fan_thermal_sched.sv
// Fan PWM scheduler: temperature samples map to a 4-bit duty level with hysteresis,
// critical override and one-step slewing; the tachometer is watched for a stalled fan.
module fan_thermal_sched #(
    parameter int unsigned TEMP_W      = 12,
    parameter int unsigned T_LO        = 2400,
    parameter int unsigned STEP_LOG2   = 5,
    parameter int unsigned HYST        = 16,
    parameter int unsigned T_CRIT      = 3200,
    parameter int unsigned RAMP_CYCLES = 50000,
    parameter int unsigned TACH_WINDOW = 5000000,
    parameter int unsigned TACH_MIN    = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              temp_valid_i,
    input  logic [TEMP_W-1:0] temp_i,
    output logic              temp_ready_o,
    input  logic              force_full_i,
    input  logic              tach_i,
    input  logic              stall_clr_i,
    output logic [3:0]        pwm_setting_o,
    output logic              alarm_o,
    output logic              stall_o
);

    localparam int unsigned EXT_W  = TEMP_W + 1;
    localparam int unsigned RAMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam int unsigned WIN_W  = (TACH_WINDOW > 1) ? $clog2(TACH_WINDOW) : 1;
    localparam logic [EXT_W-1:0] T_MAX = EXT_W'((2 ** TEMP_W) - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EVAL = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              ready_d;
    logic [TEMP_W-1:0] temp_q, temp_d;
    logic [3:0]        target_q, target_d;
    logic              alarm_d;
    logic [EXT_W-1:0]  temp_ext, hys_sum, hys_sat;
    logic [3:0]        raw_t, raw_h;

    logic [RAMP_W-1:0] ramp_cnt_q;
    logic [2:0]        tach_sync_q;
    logic              rise_c;
    logic [7:0]        edge_cnt_q, edge_sum;
    logic [WIN_W-1:0]  win_cnt_q;
    logic              run_all_q;
    logic              win_end, stall_set;

    // Level for a temperature code: 0 below T_LO, then one level per 2**STEP_LOG2 codes.
    function automatic logic [3:0] raw_level(input logic [EXT_W-1:0] t);
        logic [EXT_W-1:0] d;
        if (t < EXT_W'(T_LO)) begin
            return 4'd0;
        end
        d = (t - EXT_W'(T_LO)) >> STEP_LOG2;
        if (d >= EXT_W'(14)) begin
            return 4'd15;
        end
        return 4'(d) + 4'd1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            temp_ready_o <= 1'b0;
            temp_q       <= '0;
            target_q     <= 4'd15;
            alarm_o      <= 1'b0;
        end else begin
            state_q      <= state_d;
            temp_ready_o <= ready_d;
            temp_q       <= temp_d;
            target_q     <= target_d;
            alarm_o      <= alarm_d;
        end
    end

    // Sample intake and target evaluation; raising uses t, lowering uses t+HYST.
    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b0;
        temp_d   = temp_q;
        target_d = target_q;
        alarm_d  = alarm_o;
        temp_ext = {1'b0, temp_q};
        hys_sum  = temp_ext + EXT_W'(HYST);
        hys_sat  = (hys_sum > T_MAX) ? T_MAX : hys_sum;
        raw_t    = raw_level(temp_ext);
        raw_h    = raw_level(hys_sat);
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (temp_valid_i && temp_ready_o) begin
                    temp_d  = temp_i;
                    state_d = EVAL;
                    ready_d = 1'b0;
                end
            end
            EVAL: begin
                state_d = IDLE;
                ready_d = 1'b1;
                if (temp_ext >= EXT_W'(T_CRIT)) begin
                    target_d = 4'd15;
                    alarm_d  = 1'b1;
                end else begin
                    alarm_d = 1'b0;
                    if (raw_t > target_q) begin
                        target_d = raw_t;
                    end else if (raw_h < target_q) begin
                        target_d = raw_h;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output slew: one step per ramp period, overridden straight to full.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_setting_o <= 4'd15;
            ramp_cnt_q    <= '0;
        end else if (force_full_i || alarm_o) begin
            pwm_setting_o <= 4'd15;
            ramp_cnt_q    <= '0;
        end else if (ramp_cnt_q == RAMP_W'(RAMP_CYCLES - 1)) begin
            ramp_cnt_q <= '0;
            if (pwm_setting_o < target_q) begin
                pwm_setting_o <= pwm_setting_o + 4'd1;
            end else if (pwm_setting_o > target_q) begin
                pwm_setting_o <= pwm_setting_o - 4'd1;
            end
        end else begin
            ramp_cnt_q <= ramp_cnt_q + RAMP_W'(1);
        end
    end

    assign rise_c    = tach_sync_q[1] & ~tach_sync_q[2];
    assign edge_sum  = (edge_cnt_q == 8'hFF) ? 8'hFF : edge_cnt_q + 8'(rise_c);
    assign win_end   = (win_cnt_q == WIN_W'(TACH_WINDOW - 1));
    assign stall_set = win_end && run_all_q && (pwm_setting_o >= 4'd4)
                       && (32'(edge_sum) < TACH_MIN);

    // Tach edge counting per window; the last window cycle is included in the verdict.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tach_sync_q <= '0;
            edge_cnt_q  <= '0;
            win_cnt_q   <= '0;
            run_all_q   <= 1'b1;
            stall_o     <= 1'b0;
        end else begin
            tach_sync_q <= {tach_sync_q[1:0], tach_i};
            if (win_end) begin
                win_cnt_q  <= '0;
                edge_cnt_q <= '0;
                run_all_q  <= 1'b1;
            end else begin
                win_cnt_q  <= win_cnt_q + WIN_W'(1);
                edge_cnt_q <= edge_sum;
                run_all_q  <= run_all_q && (pwm_setting_o >= 4'd4);
            end
            stall_o <= stall_set || (stall_o && !stall_clr_i);
        end
    end

endmodule

// File: tb/tb_fan_thermal_sched.sv
// Randomised and directed bench for fan_thermal_sched against a behavioural model.
module tb_fan_thermal_sched;

    localparam int RC    = 8;
    localparam int TW    = 200;
    localparam int TLO   = 2400;
    localparam int TCRIT = 3200;
    localparam int HYS   = 16;
    localparam int TMIN  = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        temp_valid_i = 1'b0;
    logic [11:0] temp_i = '0;
    logic        temp_ready_o;
    logic        force_full_i = 1'b0;
    logic        tach_i = 1'b0;
    logic        stall_clr_i = 1'b0;
    logic [3:0]  pwm_setting_o;
    logic        alarm_o;
    logic        stall_o;

    int checks = 0;
    int errors = 0;
    int tach_half = 0;
    int tach_ph = 0;

    fan_thermal_sched #(.RAMP_CYCLES(RC), .TACH_WINDOW(TW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .temp_valid_i(temp_valid_i), .temp_i(temp_i),
        .temp_ready_o(temp_ready_o), .force_full_i(force_full_i), .tach_i(tach_i),
        .stall_clr_i(stall_clr_i), .pwm_setting_o(pwm_setting_o), .alarm_o(alarm_o),
        .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference level mapping from plain arithmetic.
    function automatic int m_raw(input int t);
        int r;
        if (t < TLO) return 0;
        r = 1 + (t - TLO) / 32;
        return (r > 15) ? 15 : r;
    endfunction

    function automatic int m_hsat(input int t);
        return (t + HYS > 4095) ? 4095 : t + HYS;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    int m_pwm, m_tgt, m_alarm, m_stall, m_ready, m_eval, m_samp, m_age;
    int m_win, m_edges, m_minp;
    int o_pwm, o_tgt, o_alarm, r_t, r_h;
    bit [2:0] m_td;
    bit m_rise, m_set;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_pwm = 15; m_tgt = 15; m_alarm = 0; m_stall = 0; m_ready = 0; m_eval = 0;
            m_samp = 0; m_age = 0; m_win = 0; m_edges = 0; m_minp = 15; m_td = '0;
        end else begin
            o_pwm = m_pwm; o_tgt = m_tgt; o_alarm = m_alarm;
            // tach: edge seen two cycles after the bench drives it
            m_rise = m_td[1] && !m_td[2];
            m_td = {m_td[1:0], tach_i};
            m_edges = (m_edges + int'(m_rise) > 255) ? 255 : m_edges + int'(m_rise);
            if (o_pwm < m_minp) m_minp = o_pwm;
            m_set = 1'b0;
            if (m_win == TW - 1) begin
                m_set = (m_minp >= 4) && (m_edges < TMIN);
                m_win = 0; m_edges = 0; m_minp = 15;
            end else begin
                m_win++;
            end
            if (m_set) m_stall = 1;
            else if (stall_clr_i) m_stall = 0;
            // output level
            if (force_full_i || o_alarm != 0) begin
                m_pwm = 15; m_age = 0;
            end else if (m_age == RC - 1) begin
                m_age = 0;
                if (o_pwm < o_tgt) m_pwm = o_pwm + 1;
                else if (o_pwm > o_tgt) m_pwm = o_pwm - 1;
            end else begin
                m_age++;
            end
            // sample handling
            if (m_eval != 0) begin
                if (m_samp >= TCRIT) begin
                    m_tgt = 15; m_alarm = 1;
                end else begin
                    m_alarm = 0;
                    r_t = m_raw(m_samp);
                    r_h = m_raw(m_hsat(m_samp));
                    if (r_t > o_tgt) m_tgt = r_t;
                    else if (r_h < o_tgt) m_tgt = r_h;
                end
                m_eval = 0; m_ready = 1;
            end else if (temp_valid_i && m_ready != 0) begin
                m_samp = int'(temp_i); m_eval = 1; m_ready = 0;
            end else begin
                m_ready = 1;
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            chk("pwm", int'(pwm_setting_o), m_pwm);
            chk("ready", int'(temp_ready_o), m_ready);
            chk("alarm", int'(alarm_o), m_alarm);
            chk("stall", int'(stall_o), m_stall);
        end
    end

    // Periodic tach generator (idle when tach_half is 0)
    initial begin
        forever begin
            @(negedge clk_i);
            if (tach_half != 0) begin
                tach_ph++;
                if (tach_ph >= tach_half) begin
                    tach_ph = 0;
                    tach_i = ~tach_i;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send(input int t);
        int n;
        n = 0;
        @(negedge clk_i);
        temp_valid_i = 1'b1;
        temp_i = 12'(t);
        while (!temp_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 20) chk("send_timeout", n, 0);
        @(negedge clk_i);
        temp_valid_i = 1'b0;
    endtask

    initial begin
        // model pins
        chk("raw2399", m_raw(2399), 0);
        chk("raw2400", m_raw(2400), 1);
        chk("raw2500", m_raw(2500), 4);
        chk("raw2480", m_raw(2480), 3);
        chk("raw2496", m_raw(m_hsat(2480)), 4);
        chk("raw2460", m_raw(2460), 2);
        chk("raw4095", m_raw(4095), 15);
        chk("hsat", m_hsat(4090), 4095);

        repeat (3) @(negedge clk_i);
        chk("rst_pwm", int'(pwm_setting_o), 15);
        chk("rst_ready", int'(temp_ready_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("first_ready", int'(temp_ready_o), 1);
        chk("first_pwm", int'(pwm_setting_o), 15);

        send(2000);
        wait_cyc(15 * RC + 20);
        chk("ramp_to_0", int'(pwm_setting_o), 0);

        send(2500);
        wait_cyc(4 * RC + 20);
        chk("tgt4", int'(pwm_setting_o), 4);
        send(2480);
        wait_cyc(3 * RC);
        chk("hyst_hold", int'(pwm_setting_o), 4);
        send(2460);
        wait_cyc(3 * RC);
        chk("hyst_drop", int'(pwm_setting_o), 3);

        send(3300);
        wait_cyc(2);
        chk("crit_alarm", int'(alarm_o), 1);
        chk("crit_pwm", int'(pwm_setting_o), 15);
        send(2000);
        wait_cyc(2);
        chk("crit_release", int'(alarm_o), 0);
        wait_cyc(15 * RC + 20);
        chk("crit_ramp", int'(pwm_setting_o), 0);

        send(2440);
        wait_cyc(2 * RC + 20);
        chk("lvl2", int'(pwm_setting_o), 2);
        @(negedge clk_i) force_full_i = 1'b1;
        @(negedge clk_i) force_full_i = 1'b0;
        chk("force_full", int'(pwm_setting_o), 15);
        wait_cyc(13 * RC + 10);
        chk("force_ramp", int'(pwm_setting_o), 2);

        // stall: level 7, 2 edges per window
        send(2600);
        wait_cyc(5 * RC + 10);
        tach_half = 50;
        wait_cyc(3 * TW);
        chk("stall_set", int'(stall_o), 1);
        tach_half = 16;
        wait_cyc(2 * TW + 10);
        @(negedge clk_i) stall_clr_i = 1'b1;
        @(negedge clk_i) stall_clr_i = 1'b0;
        chk("stall_clr", int'(stall_o), 0);
        wait_cyc(3 * TW);
        chk("stall_stays0", int'(stall_o), 0);

        // randomised traffic
        tach_half = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_i);
            temp_valid_i = ($urandom_range(0, 3) == 0);
            temp_i = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(2250, 3350));
            force_full_i = ($urandom_range(0, 99) < 2);
            stall_clr_i = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 8) tach_i = ~tach_i;
        end
        force_full_i = 1'b0;
        stall_clr_i = 1'b0;
        temp_valid_i = 1'b0;

        // asynchronous reset in mid-operation
        send(2300);
        wait_cyc(3);
        #3 rst_ni = 1'b0;
        #1;
        chk("async_pwm", int'(pwm_setting_o), 15);
        chk("async_ready", int'(temp_ready_o), 0);
        chk("async_alarm", int'(alarm_o), 0);
        chk("async_stall", int'(stall_o), 0);
        wait_cyc(2);
        rst_ni = 1'b1;
        wait_cyc(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
